// File: rtl/awg_param_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | awg_param_ctrl : key debounce, auto-repeat and select/edit of DDS params |
// | Revision 1.0   : initial release                                         |
// +--------------------------------------------------------------------------+
module awg_param_ctrl #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_RATE     = 5000000,
   parameter int FREQ_STEP       = 16,
   parameter int FREQ_INIT       = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        key_sel,
   input  logic        key_up,
   input  logic        key_dn,
   input  logic        key_en,
   output logic        en,
   output logic [11:0] freq,
   output logic [2:0]  amp,
   output logic [7:0]  phase,
   output logic [1:0]  sel,
   output logic        upd
);

   localparam int              DW         = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [DW-1:0]   DEB_MAX    = DW'(DEBOUNCE_CYCLES - 1);
   localparam int              RW         = $clog2(REPEAT_DELAY + 1);
   localparam logic [RW-1:0]   REP_FIRE   = RW'(REPEAT_DELAY);
   localparam logic [RW-1:0]   REP_RELOAD = RW'(REPEAT_DELAY - REPEAT_RATE + 1);
   localparam logic [12:0]     FSTEP13    = 13'(FREQ_STEP);
   localparam logic [11:0]     FSTEP12    = 12'(FREQ_STEP);
   localparam logic [11:0]     FMAX       = 12'd4095;

   typedef enum logic [1:0] {
      S_FREQ  = 2'd0,
      S_AMP   = 2'd1,
      S_PHASE = 2'd2
   } sel_t;

   sel_t        state;
   logic [3:0]  raw;
   logic [3:0]  held;
   logic [3:0]  press;
   logic        both;
   logic [1:0]  step;
   logic [12:0] f_up;
   logic [11:0] f_dn;
   logic        n_en;
   logic [11:0] n_freq;
   logic [2:0]  n_amp;
   logic [7:0]  n_phase;

   // Bit order: 0 = sel, 1 = up, 2 = dn, 3 = en; held/press are active-high
   assign raw = {key_en, key_dn, key_up, key_sel};

   for (genvar i = 0; i < 4; i++) begin : g_key
      logic          s1;
      logic          s2;
      logic          lvl;
      logic          evt;
      logic [DW-1:0] cnt;

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            s1  <= 1'b1;
            s2  <= 1'b1;
            lvl <= 1'b0;
            evt <= 1'b0;
            cnt <= '0;
         end else begin
            s1  <= raw[i];
            s2  <= s1;
            evt <= 1'b0;
            if (~s2 != lvl) begin
               if (cnt == DEB_MAX) begin
                  lvl <= ~s2;
                  evt <= ~s2;
                  cnt <= '0;
               end else begin
                  cnt <= cnt + DW'(1);
               end
            end else begin
               cnt <= '0;
            end
         end
      end

      assign held[i]  = lvl;
      assign press[i] = evt;
   end

   // Opposing keys cancel each other completely, including the hold timers
   assign both = held[1] & held[2];

   for (genvar j = 0; j < 2; j++) begin : g_rep
      logic [RW-1:0] hold;

      always_ff @(posedge clk) begin
         if (!rst_n || !held[j+1] || both) begin
            hold <= '0;
         end else if (hold == REP_FIRE) begin
            hold <= REP_RELOAD;
         end else begin
            hold <= hold + RW'(1);
         end
      end

      assign step[j] = ~both & (press[j+1] | (held[j+1] & (hold == REP_FIRE)));
   end

   assign f_up = {1'b0, freq} + FSTEP13;
   assign f_dn = freq - FSTEP12;

   always_comb begin
      n_en    = en ^ press[3];
      n_freq  = freq;
      n_amp   = amp;
      n_phase = phase;
      case (state)
         S_FREQ: begin
            if (step[0]) begin
               n_freq = (f_up > {1'b0, FMAX}) ? FMAX : f_up[11:0];
            end else if (step[1]) begin
               n_freq = ({1'b0, freq} <= FSTEP13) ? 12'd1 : f_dn;
            end
         end
         S_AMP: begin
            if (step[0] && amp != 3'd7) begin
               n_amp = amp + 3'd1;
            end else if (step[1] && amp > 3'd1) begin
               n_amp = amp - 3'd1;
            end
         end
         S_PHASE: begin
            if (step[0]) begin
               n_phase = phase + 8'd1;
            end else if (step[1]) begin
               n_phase = phase - 8'd1;
            end
         end
         default: begin
         end
      endcase
   end

   // Steps use the pre-transition selection; state 3 falls back to FREQ
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= S_FREQ;
         en    <= 1'b0;
         freq  <= 12'(FREQ_INIT);
         amp   <= 3'd1;
         phase <= 8'd0;
         upd   <= 1'b0;
      end else begin
         en    <= n_en;
         freq  <= n_freq;
         amp   <= n_amp;
         phase <= n_phase;
         upd   <= (n_en != en) | (n_freq != freq) | (n_amp != amp) | (n_phase != phase);
         case (state)
            S_FREQ:  if (press[0]) state <= S_AMP;
            S_AMP:   if (press[0]) state <= S_PHASE;
            S_PHASE: if (press[0]) state <= S_FREQ;
            default: state <= S_FREQ;
         endcase
      end
   end

   assign sel = state;

endmodule
`default_nettype wire

// File: doc/awg_param_ctrl.md
# awg_param_ctrl

Front-panel parameter controller for the AWG channel generators. It debounces four push-buttons and runs a select/edit state machine. It holds the channel settings `en`, `freq`, `amp` and `phase` in registers and drives them directly into the DDS waveform generator inputs of the same names. It sits between the board key pins and the generator; all outputs are registered and stable between edits.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles required to accept a key level (10 ms at 50 MHz).
- `REPEAT_DELAY`, default 25000000: hold time before auto-repeat starts.
- `REPEAT_RATE`, default 5000000: cycles between auto-repeat steps.
- `FREQ_STEP`, default 16: `freq` increment per step.
- `FREQ_INIT`, default 64: `freq` value after reset.

Ports:
- `clk` in 1: system clock; one clock domain; shared with the generator.
- `rst_n` in 1: reset, synchronous, active-low.
- `key_sel` in 1: raw button, active-low, asynchronous; cycles the edited parameter.
- `key_up` in 1: raw button, active-low, asynchronous; steps the selected parameter up.
- `key_dn` in 1: raw button, active-low, asynchronous; steps the selected parameter down.
- `key_en` in 1: raw button, active-low, asynchronous; toggles output enable.
- `en` out 1: generator enable.
- `freq` out 12: phase-accumulator increment.
- `amp` out 3: amplitude divisor; legal range 1..7.
- `phase` out 8: channel-B phase offset in table steps.
- `sel` out 2: selected parameter; 0 = FREQ, 1 = AMP, 2 = PHASE; drives LEDs.
- `upd` out 1: one-cycle pulse when any of `en`/`freq`/`amp`/`phase` changed value.

## Operation
- Each key passes through a 2-flop synchronizer, then a debouncer.
  - The debounce counter restarts whenever the synchronized level differs from the debounced level.
  - The debounced level flips after `DEBOUNCE_CYCLES` consecutive differing cycles.
  - Press event = debounced level transitions released to pressed. This is a single-cycle strobe.
- Select FSM, states FREQ, AMP, PHASE:
  - A `key_sel` press advances the state FREQ -> AMP -> PHASE -> FREQ.
  - `sel` encodes the state. Encoding 3 is unreachable; if entered, it recovers to FREQ on the next cycle.
- Step generation for `key_up`/`key_dn`:
  - The press event produces one step.
  - While the key is still debounced-pressed, a second step occurs `REPEAT_DELAY` cycles after the press event, then one step every `REPEAT_RATE` cycles.
  - Releasing the key clears the hold counter.
  - If up and down are both debounced-pressed, no steps are produced and both hold counters are held at zero.
- Step application, by selected parameter:
  - FREQ: ±`FREQ_STEP`, computed in 13 bits, saturating to the range 1..4095. `freq` never reaches 0, because 0 would stall the accumulator.
  - AMP: ±1, saturating to 1..7. `amp` is a divisor, so 0 is never produced.
  - PHASE: ±1 modulo 256. 255+1 = 0 and 0−1 = 255.
- `key_en` press toggles `en`. It is independent of `sel` and does not alter the other parameters.
- Simultaneous events in one cycle:
  - A `key_sel` press together with a step: the step applies to the parameter selected before the `sel` change.
  - A `key_en` press together with a step: both take effect.
- `upd` is asserted for exactly one cycle after a cycle in which any output register changed value. A saturated step with no value change produces no `upd`.

## Timing
- Reset (`rst_n` = 0 at a clock edge) sets:
  - `en` = 0, `freq` = `FREQ_INIT`, `amp` = 1, `phase` = 0, `sel` = 0, `upd` = 0.
  - All debounced levels to released; all counters to 0.
- Reset asserted mid-hold or mid-debounce discards the pending event. After release, a key still held must re-debounce: a full `DEBOUNCE_CYCLES` before any press event.
- Latency from a raw key settling low to the output register change is `DEBOUNCE_CYCLES` + 3 cycles: 2 synchronizer cycles, the debounce accept, and the output register.
- `upd` rises in the same cycle the new output value is first visible.
- Glitches on a raw key shorter than `DEBOUNCE_CYCLES` cycles produce no event.
- All outputs change only on `clk` rising edges. No combinational path exists from inputs to outputs.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES` = 4, `REPEAT_DELAY` = 20, `REPEAT_RATE` = 5, `FREQ_STEP` = 16, `FREQ_INIT` = 64.
- Reset: hold `rst_n` = 0 for 3 cycles -> outputs read en = 0, freq = 64, amp = 1, phase = 0, sel = 0, upd = 0.
- Debounce: a 3-cycle low pulse on `key_up` -> no change. A 10-cycle low pulse -> freq = 80 exactly 7 cycles after the falling edge, with one `upd` pulse.
- Auto-repeat: hold `key_up` 40 cycles in FREQ -> steps at press+0, +20, +25, +30, +35 -> freq = 144, and 5 `upd` pulses.
- Saturation and wrap:
  - In AMP, seven `key_dn` presses from 1 -> amp stays 1, no `upd`.
  - In PHASE from 0, one `key_dn` press -> phase = 255.
  - In FREQ at 4090, `key_up` -> 4095.
- Selection and concurrency:
  - Three `key_sel` presses -> sel sequence 1, 2, 0.
  - `key_sel` and `key_up` pressed in the same cycle while in FREQ -> freq += 16 and sel = 1.
  - `key_up` and `key_dn` held together -> no change.
- Enable and mid-op reset:
  - `key_en` press -> en = 1; a second press -> en = 0.
  - Assert `rst_n` while `key_up` is held mid-repeat -> reset values. After release, no step until 4 debounce cycles have elapsed.
